// File: rtl/dcsk_pkg.sv
// Shared types and constants for the DCSK transmit sequencer.
// Pure declarations: no logic and no latency of its own.
package dcsk_pkg;

    localparam int WORD_W    = 32;
    localparam int BIT_IDX_W = 5;
    localparam int MIN_SF    = 2;
    localparam int MAX_SF    = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REF_SLOT  = 2'd1,
        DATA_SLOT = 2'd2
    } tx_state_t;

    // Below 2 chips the slot cannot hold a reference; above 16 it would overrun the delay register.
    function automatic int unsigned clamp_sf(input int unsigned sf);
        if (sf < MIN_SF) begin
            return MIN_SF;
        end else if (sf > MAX_SF) begin
            return MAX_SF;
        end
        return sf;
    endfunction

endpackage

// File: rtl/dcsk_tx_controller_if.sv
// Word handshake plus chip-rate control bundle between the word source and the DCSK sequencer.
// master = word source / datapath side, slave = sequencer.
interface dcsk_tx_controller_if #(
    parameter int WORD_W = 32,
    parameter int ADDR_W = 4,
    parameter int SF_W   = 5
);
    logic              Enable;
    logic              In_Valid;
    logic [WORD_W-1:0] In_Data;
    logic              In_Ready;
    logic [SF_W-1:0]   Spread_Factor;
    logic              Chaos_Gen_En;
    logic [ADDR_W-1:0] Var_Del_Reg_Addr;
    logic              Var_Del_Reg_Load;
    logic              Var_Del_Reg_Re;
    logic              Slot_Sel;
    logic              Chip_Invert;
    logic              Tx_Valid;
    logic [4:0]        Bit_Idx;
    logic              Word_Done;
    logic              Abort;
    logic              Busy;

    modport master (
        output Enable, In_Valid, In_Data, Spread_Factor,
        input  In_Ready, Chaos_Gen_En, Var_Del_Reg_Addr, Var_Del_Reg_Load, Var_Del_Reg_Re,
               Slot_Sel, Chip_Invert, Tx_Valid, Bit_Idx, Word_Done, Abort, Busy
    );

    modport slave (
        input  Enable, In_Valid, In_Data, Spread_Factor,
        output In_Ready, Chaos_Gen_En, Var_Del_Reg_Addr, Var_Del_Reg_Load, Var_Del_Reg_Re,
               Slot_Sel, Chip_Invert, Tx_Valid, Bit_Idx, Word_Done, Abort, Busy
    );
endinterface

// File: rtl/dcsk_chip_counter.sv
// Wrapping up-counter: counts 0..i_term while enabled, synchronous clear has priority.
// o_last is combinational from the registered count; no backpressure.
module dcsk_chip_counter #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clear,
    input  logic         i_en,
    input  logic [W-1:0] i_term,
    output logic [W-1:0] o_count,
    output logic         o_last
);
    logic [W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= o_last ? '0 : r_count + W'(1);
        end
    end

    assign o_count = r_count;
    assign o_last  = (r_count == i_term);
endmodule

// File: rtl/dcsk_tx_controller.sv
// DCSK transmit sequencer: per bit, a reference slot that records chaos chips, then a data slot replaying them.
// First chip one cycle after acceptance; In_Ready drops while a word is in flight except on its final chip.
module dcsk_tx_controller #(
    parameter int WORD_W = 32,
    parameter int ADDR_W = 4,
    parameter int SF_W   = 5
) (
    input logic                 Clk,
    input logic                 Rst,
    dcsk_tx_controller_if.slave bus
);
    import dcsk_pkg::*;

    localparam int CHIP_W = ADDR_W + 1;

    tx_state_t           r_state;
    logic [WORD_W-1:0]   r_word;
    logic [CHIP_W-1:0]   r_sf;
    logic                r_abort;

    logic [CHIP_W-1:0]    w_chip;
    logic                 w_chip_last;
    logic [BIT_IDX_W-1:0] w_bit;
    logic                 w_bit_last;
    logic                 w_active;
    logic                 w_ref;
    logic                 w_data;
    logic                 w_word_last;
    logic                 w_abort;
    logic                 w_accept;
    logic                 w_cnt_clear;
    logic                 w_unused_chip_msb;

    assign w_active    = (r_state != IDLE);
    assign w_ref       = (r_state == REF_SLOT);
    assign w_data      = (r_state == DATA_SLOT);
    assign w_word_last = w_data & w_chip_last & w_bit_last;
    assign w_abort     = w_active & ~bus.Enable;
    assign w_accept    = bus.In_Valid & bus.In_Ready;
    assign w_cnt_clear = ~w_active | w_abort | w_accept;

    // Ready on the final chip lets the next word start with no bubble.
    assign bus.In_Ready = bus.Enable & (~w_active | w_word_last);

    dcsk_chip_counter #(.W(CHIP_W)) u_chip_cnt (
        .clk     (Clk),
        .rst     (Rst),
        .i_clear (w_cnt_clear),
        .i_en    (w_active),
        .i_term  (r_sf - CHIP_W'(1)),
        .o_count (w_chip),
        .o_last  (w_chip_last)
    );

    dcsk_chip_counter #(.W(BIT_IDX_W)) u_bit_cnt (
        .clk     (Clk),
        .rst     (Rst),
        .i_clear (w_cnt_clear),
        .i_en    (w_data & w_chip_last),
        .i_term  (BIT_IDX_W'(WORD_W - 1)),
        .o_count (w_bit),
        .o_last  (w_bit_last)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state <= IDLE;
            r_word  <= '0;
            r_sf    <= '0;
            r_abort <= 1'b0;
        end else begin
            r_abort <= w_abort;
            if (w_abort) begin
                r_state <= IDLE;
            end else if (w_accept) begin
                r_state <= REF_SLOT;
                r_word  <= bus.In_Data;
                r_sf    <= CHIP_W'(clamp_sf(32'(bus.Spread_Factor)));
            end else begin
                case (r_state)
                    REF_SLOT:  if (w_chip_last) r_state <= DATA_SLOT;
                    DATA_SLOT: if (w_chip_last) r_state <= w_bit_last ? IDLE : REF_SLOT;
                    default:   r_state <= IDLE;
                endcase
            end
        end
    end

    // sf_q never exceeds 16, so the counter MSB is only reached as a comparison value.
    assign w_unused_chip_msb = w_chip[ADDR_W];

    assign bus.Tx_Valid         = w_active;
    assign bus.Busy             = w_active;
    assign bus.Slot_Sel         = w_data;
    assign bus.Chaos_Gen_En     = w_ref;
    assign bus.Var_Del_Reg_Load = w_ref;
    assign bus.Var_Del_Reg_Re   = w_data;
    assign bus.Chip_Invert      = w_data & ~r_word[w_bit];
    assign bus.Var_Del_Reg_Addr = w_active ? w_chip[ADDR_W-1:0] : '0;
    assign bus.Bit_Idx          = w_bit;
    assign bus.Word_Done        = w_word_last & bus.Enable;
    assign bus.Abort            = r_abort;
endmodule

// File: tb/tb_dcsk_tx_controller.sv
// Bench for dcsk_tx_controller: directed scenarios plus random traffic against a word-position reference model.
module tb_dcsk_tx_controller;
    logic Clk = 1'b0;
    logic Rst;

    always #5 Clk = ~Clk;

    dcsk_tx_controller_if #(.WORD_W(32), .ADDR_W(4), .SF_W(5)) bus ();

    dcsk_tx_controller #(.WORD_W(32), .ADDR_W(4), .SF_W(5)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: a word is one linear chip position p in 0..64*sf-1.
    bit          m_busy  = 1'b0;
    bit          m_abort = 1'b0;
    int unsigned m_p     = 0;
    int unsigned m_sf    = 2;
    logic [31:0] m_word  = '0;

    int tx_cnt, done_cnt, abort_cnt, max_addr;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] dut_ctrl();
        return 32'({bus.Busy, bus.Tx_Valid, bus.Slot_Sel, bus.Chaos_Gen_En, bus.Var_Del_Reg_Load,
                    bus.Var_Del_Reg_Re, bus.Chip_Invert, bus.Word_Done, bus.Abort});
    endfunction

    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic step();
        int unsigned bit_i, w, chip;
        bit dslot, last, acc, en;
        #1;
        en = bus.Enable;
        if (m_busy) begin
            bit_i = m_p / (2 * m_sf);
            w     = m_p % (2 * m_sf);
            dslot = (w >= m_sf);
            chip  = w % m_sf;
            last  = (m_p == 64 * m_sf - 1);
        end else begin
            bit_i = 0; dslot = 1'b0; chip = 0; last = 1'b0;
        end
        check_eq("ctrl", dut_ctrl(),
                 32'({m_busy, m_busy, m_busy & dslot, m_busy & !dslot, m_busy & !dslot,
                      m_busy & dslot, m_busy & dslot & !m_word[bit_i], last & en, m_abort}));
        check_eq("addr", 32'(bus.Var_Del_Reg_Addr), chip);
        check_eq("bit_idx", 32'(bus.Bit_Idx), bit_i);
        check_eq("in_ready", 32'(bus.In_Ready), 32'(en & (!m_busy | last)));

        tx_cnt    += int'(bus.Tx_Valid);
        done_cnt  += int'(bus.Word_Done);
        abort_cnt += int'(bus.Abort);
        if (int'(bus.Var_Del_Reg_Addr) > max_addr) max_addr = int'(bus.Var_Del_Reg_Addr);

        acc     = bus.In_Valid & en & (!m_busy | last);
        m_abort = m_busy & !en;
        if (m_busy && !en) begin
            m_busy = 1'b0;
            m_p    = 0;
        end else if (acc) begin
            m_busy = 1'b1;
            m_p    = 0;
            m_word = bus.In_Data;
            m_sf   = int'(bus.Spread_Factor);
            if (m_sf < 2)  m_sf = 2;
            if (m_sf > 16) m_sf = 16;
        end else if (m_busy) begin
            if (last) m_busy = 1'b0;
            else      m_p++;
        end
        @(negedge Clk);
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_stats();
        tx_cnt = 0; done_cnt = 0; abort_cnt = 0; max_addr = 0;
    endtask

    task automatic send_word(input logic [4:0] sf, input logic [31:0] data);
        bus.In_Valid      = 1'b1;
        bus.In_Data       = data;
        bus.Spread_Factor = sf;
        step();
        bus.In_Valid = 1'b0;
    endtask

    // Reset is asynchronous: outputs must already be clear 1 ns after Rst rises.
    task automatic apply_reset();
        Rst = 1'b1;
        #1;
        check_eq("rst_ctrl", dut_ctrl(), 32'd0);
        check_eq("rst_addr", 32'(bus.Var_Del_Reg_Addr), 32'd0);
        check_eq("rst_bit", 32'(bus.Bit_Idx), 32'd0);
        check_eq("rst_ready", 32'(bus.In_Ready), 32'(bus.Enable));
        m_busy = 1'b0; m_abort = 1'b0; m_p = 0;
        @(negedge Clk);
        Rst = 1'b0;
    endtask

    initial begin
        logic [4:0] sf_tab [3];
        int         len_tab[3];
        int         guard;

        Rst = 1'b1;
        bus.Enable = 1'b0; bus.In_Valid = 1'b0; bus.In_Data = '0; bus.Spread_Factor = '0;
        clear_stats();
        @(negedge Clk);
        apply_reset();
        run_cycles(2);

        // SF=4, one word
        bus.Enable = 1'b1;
        clear_stats();
        send_word(5'd4, 32'hA5A5_A5A5);
        run_cycles(260);
        check_eq("a_tx_cycles", tx_cnt, 256);
        check_eq("a_word_done", done_cnt, 1);

        // back-to-back with In_Valid held, SF=2
        clear_stats();
        bus.In_Valid = 1'b1; bus.In_Data = 32'hFFFF_FFFF; bus.Spread_Factor = 5'd2;
        step();
        bus.In_Data = 32'h0000_0000;
        guard = 0;
        while (done_cnt < 1 && guard < 300) begin step(); guard++; end
        bus.In_Valid = 1'b0;
        guard = 0;
        while (done_cnt < 2 && guard < 300) begin step(); guard++; end
        run_cycles(3);
        check_eq("b_tx_cycles", tx_cnt, 256);
        check_eq("b_word_done", done_cnt, 2);

        // SF clamping
        sf_tab  = '{5'd0, 5'd1, 5'd31};
        len_tab = '{128, 128, 1024};
        for (int k = 0; k < 3; k++) begin
            clear_stats();
            send_word(sf_tab[k], $urandom);
            run_cycles(len_tab[k] + 4);
            check_eq("c_tx_cycles", tx_cnt, len_tab[k]);
            check_eq("c_word_done", done_cnt, 1);
            check_eq("c_addr_le15", 32'(max_addr <= 15), 32'd1);
        end

        // Abort at bit 7, data slot chip 2, SF=8 with a mid-word SF change to 5
        clear_stats();
        send_word(5'd8, $urandom);
        guard = 0;
        while (m_p != 7 * 16 + 8 + 2 && guard < 400) begin
            if (m_p == 40) bus.Spread_Factor = 5'd5;
            step();
            guard++;
        end
        check_eq("d_reach_pos", m_p, 7 * 16 + 8 + 2);
        bus.Enable   = 1'b0;
        bus.In_Valid = 1'b1;
        run_cycles(6);
        check_eq("d_abort_pulses", abort_cnt, 1);
        check_eq("d_word_done", done_cnt, 0);
        bus.In_Valid = 1'b0;
        bus.Enable   = 1'b1;
        run_cycles(3);

        // Reset mid-word at bit 3, reference chip 10 (SF=12), then a fresh word
        send_word(5'd12, $urandom);
        guard = 0;
        while (m_p != 3 * 24 + 10 && guard < 300) begin step(); guard++; end
        check_eq("e_reach_pos", m_p, 3 * 24 + 10);
        apply_reset();
        clear_stats();
        send_word(5'd3, $urandom);
        run_cycles(64 * 3 + 3);
        check_eq("e_tx_cycles", tx_cnt, 192);

        // Random traffic
        for (int i = 0; i < 5000; i++) begin
            bus.Enable        = ($urandom_range(0, 299) != 0);
            bus.In_Valid      = ($urandom_range(0, 3) == 0);
            bus.In_Data       = $urandom;
            bus.Spread_Factor = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31))
                                                            : 5'($urandom_range(0, 6));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
